// File: rtl/packet_to_serial.sv
`default_nettype none
// ============================================================================
// Module   : packet_to_serial
// Brief    : Buffers one whole packet, then emits a serial frame of
//            MAGIC, length low, length high and the payload bytes.
// Revision : 1.0 - initial release
// ============================================================================
module packet_to_serial #(
    parameter int         DEPTH = 64,
    parameter logic [7:0] MAGIC = 8'h51
) (
    input  logic       clock,
    input  logic       clear,
    input  logic       in_valid,
    input  logic [7:0] in_data,
    input  logic       in_last,
    output logic       in_ready,
    output logic       out_valid,
    output logic [7:0] out_data,
    input  logic       out_ready,
    output logic       out_last,
    output logic       overflow
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [2:0] {
        ST_ACCEPT   = 3'd0,
        ST_MAGIC    = 3'd1,
        ST_LEN_LO   = 3'd2,
        ST_LEN_HI   = 3'd3,
        ST_PAYLOAD  = 3'd4
    } state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   count_q, count_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [15:0]     len_q, len_d;
    logic            out_valid_q, out_valid_d;
    logic [7:0]      out_data_q, out_data_d;
    logic            out_last_q, out_last_d;
    logic            overflow_q, overflow_d;

    logic [7:0]      mem [DEPTH];
    logic [AW-1:0]   rd_addr;
    logic [7:0]      rd_byte;
    logic            in_xfer;
    logic            out_xfer;

    assign in_ready  = (state_q == ST_ACCEPT);
    assign in_xfer   = in_valid & in_ready;
    assign out_xfer  = out_valid_q & out_ready;

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;
    assign overflow  = overflow_q;

    // Prefetch address: byte 0 while finishing the header, otherwise the
    // byte following the one currently presented on out_data.
    assign rd_addr = (state_q == ST_PAYLOAD) ? (rd_ptr_q + AW'(1)) : '0;
    assign rd_byte = mem[rd_addr];

    // Payload buffer write port; contents need no reset.
    always_ff @(posedge clock) begin
        if (in_xfer) begin
            mem[count_q] <= in_data;
        end
    end

    // Next-state and registered-output computation.
    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        rd_ptr_d    = rd_ptr_q;
        len_d       = len_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        overflow_d  = 1'b0;

        unique case (state_q)
            ST_ACCEPT: begin
                if (in_xfer) begin
                    count_d = count_q + AW'(1);
                    // A full buffer closes the frame even without in_last;
                    // the remainder of the packet becomes the next frame.
                    if (in_last || (count_q == AW'(DEPTH - 1))) begin
                        len_d       = 16'(count_q) + 16'd1;
                        count_d     = '0;
                        state_d     = ST_MAGIC;
                        out_valid_d = 1'b1;
                        out_data_d  = MAGIC;
                        out_last_d  = 1'b0;
                        overflow_d  = ~in_last;
                    end
                end
            end
            ST_MAGIC: begin
                if (out_xfer) begin
                    out_data_d = len_q[7:0];
                    state_d    = ST_LEN_LO;
                end
            end
            ST_LEN_LO: begin
                if (out_xfer) begin
                    out_data_d = len_q[15:8];
                    state_d    = ST_LEN_HI;
                end
            end
            ST_LEN_HI: begin
                if (out_xfer) begin
                    out_data_d = rd_byte;
                    rd_ptr_d   = '0;
                    out_last_d = (len_q == 16'd1);
                    state_d    = ST_PAYLOAD;
                end
            end
            ST_PAYLOAD: begin
                if (out_xfer) begin
                    if (out_last_q) begin
                        state_d     = ST_ACCEPT;
                        rd_ptr_d    = '0;
                        out_valid_d = 1'b0;
                        out_data_d  = 8'h00;
                        out_last_d  = 1'b0;
                    end else begin
                        rd_ptr_d   = rd_ptr_q + AW'(1);
                        out_data_d = rd_byte;
                        out_last_d = ((16'(rd_ptr_q) + 16'd2) == len_q);
                    end
                end
            end
            default: begin
                state_d     = ST_ACCEPT;
                out_valid_d = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous clear.
    always_ff @(posedge clock) begin
        if (clear) begin
            state_q     <= ST_ACCEPT;
            count_q     <= '0;
            rd_ptr_q    <= '0;
            len_q       <= 16'd0;
            out_valid_q <= 1'b0;
            out_data_q  <= 8'h00;
            out_last_q  <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            rd_ptr_q    <= rd_ptr_d;
            len_q       <= len_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
            overflow_q  <= overflow_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_packet_to_serial.sv
`default_nettype none
// ============================================================================
// Module   : tb_packet_to_serial
// Brief    : Self-checking bench for packet_to_serial (DEPTH 64 and 512).
// Revision : 1.0 - initial release
// ============================================================================
module tb_packet_to_serial;

    localparam logic [7:0] MAGIC = 8'h51;
    localparam int         TMO   = 20000;

    logic       clk = 1'b0;
    logic       clear = 1'b1;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       in_last = 1'b0;
    logic       out_ready = 1'b1;
    logic       dsel = 1'b0;
    logic       stall = 1'b0;

    logic       a_in_ready, a_out_valid, a_out_last, a_overflow;
    logic [7:0] a_out_data;
    logic       b_in_ready, b_out_valid, b_out_last, b_overflow;
    logic [7:0] b_out_data;

    logic       in_ready, out_valid, out_last, ovf;
    logic [7:0] out_data;

    always #5 clk = ~clk;

    packet_to_serial #(.DEPTH(64), .MAGIC(MAGIC)) u_d64 (
        .clock(clk), .clear(clear),
        .in_valid(in_valid & ~dsel), .in_data(in_data), .in_last(in_last),
        .in_ready(a_in_ready),
        .out_valid(a_out_valid), .out_data(a_out_data), .out_ready(out_ready),
        .out_last(a_out_last), .overflow(a_overflow)
    );

    packet_to_serial #(.DEPTH(512), .MAGIC(MAGIC)) u_d512 (
        .clock(clk), .clear(clear),
        .in_valid(in_valid & dsel), .in_data(in_data), .in_last(in_last),
        .in_ready(b_in_ready),
        .out_valid(b_out_valid), .out_data(b_out_data), .out_ready(out_ready),
        .out_last(b_out_last), .overflow(b_overflow)
    );

    assign in_ready  = dsel ? b_in_ready  : a_in_ready;
    assign out_valid = dsel ? b_out_valid : a_out_valid;
    assign out_data  = dsel ? b_out_data  : a_out_data;
    assign out_last  = dsel ? b_out_last  : a_out_last;
    assign ovf       = dsel ? b_overflow  : a_overflow;

    int total = 0;
    int bad   = 0;

    logic [8:0] sb [$];     // {last, data} expected on the serial side
    bit         mon_en = 1'b0;
    int         ovf_cnt = 0;
    bit         pv = 1'b0, pr = 1'b0;
    logic [7:0] pdata = 8'h00;
    int         fidx = 0, cyc = 0;
    bit         in_frame = 1'b0, chk_rdy = 1'b0;
    logic [15:0] flen = 16'd0;

    typedef struct {
        int         len;
        logic [7:0] first;
        logic [7:0] step;
        bit         dsel;
        bit         stall;
        bit         b2b;
        int         exp_ovf;
    } vec_t;

    vec_t vecs [8];

    task automatic check(input bit ok, input string name, input int act, input int exp);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int depth_of(input bit s);
        return s ? 512 : 64;
    endfunction

    task automatic push_frame(input logic [7:0] pl [$]);
        int n = pl.size();
        logic [15:0] l = 16'(n);
        sb.push_back({1'b0, MAGIC});
        sb.push_back({1'b0, l[7:0]});
        sb.push_back({1'b0, l[15:8]});
        for (int i = 0; i < n; i++) begin
            sb.push_back({(i == n - 1), pl[i]});
        end
    endtask

    // Drives one packet and, when asked, pushes the frames it should produce.
    task automatic send_pkt(input int len, input logic [7:0] first,
                            input logic [7:0] step, input bit push);
        logic [7:0] pl [$];
        logic [7:0] b;
        int guard;
        for (int i = 0; i < len; i++) begin
            b = 8'(first + 8'(i) * step);
            @(negedge clk);
            guard = 0;
            while (!in_ready && guard < TMO) begin
                @(negedge clk);
                guard++;
            end
            if (guard >= TMO) begin
                check(1'b0, "in_ready_timeout", 0, 1);
                break;
            end
            in_valid = 1'b1;
            in_data  = b;
            in_last  = (i == len - 1);
            pl.push_back(b);
            if ((i == len - 1) || (pl.size() == depth_of(dsel))) begin
                if (push) push_frame(pl);
                pl.delete();
            end
            @(posedge clk);
        end
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic drain();
        int guard = 0;
        while ((sb.size() != 0 || out_valid) && guard < TMO) begin
            @(negedge clk);
            guard++;
        end
        check(guard < TMO, "drain_timeout", guard, TMO);
        @(negedge clk);
        @(negedge clk);
    endtask

    // Back-pressure generator, updated just after the rising edge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            out_ready = stall ? ~out_ready : 1'b1;
        end
    end

    // Scoreboard monitor: pops expected bytes on every output transfer.
    initial begin
        logic [8:0] e;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (ovf) ovf_cnt++;
                if (pv && !pr) begin
                    check(out_valid && (out_data == pdata), "hold_stall", out_data, pdata);
                end
                if (chk_rdy) begin
                    check(in_ready, "in_ready_after_frame", in_ready, 1);
                    chk_rdy = 1'b0;
                end
                if (out_valid) begin
                    check(!in_ready, "in_ready_low_in_send", in_ready, 0);
                    in_frame = 1'b1;
                end
                if (in_frame) cyc++;
                if (out_valid && out_ready) begin
                    if (sb.size() == 0) begin
                        check(1'b0, "unexpected_byte", out_data, 0);
                    end else begin
                        e = sb.pop_front();
                        check(out_data == e[7:0], "out_data", out_data, e[7:0]);
                        check(out_last == e[8], "out_last", out_last, e[8]);
                    end
                    if (fidx == 1) flen[7:0]  = out_data;
                    if (fidx == 2) flen[15:8] = out_data;
                    fidx++;
                    if (fidx > 3 && fidx == int'(flen) + 3) begin
                        if (!stall) check(cyc == fidx, "frame_cycles", cyc, fidx);
                        fidx = 0;
                        cyc = 0;
                        in_frame = 1'b0;
                        chk_rdy = 1'b1;
                    end
                end
                pv = out_valid;
                pr = out_ready;
                pdata = out_data;
            end
        end
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    // Main sequence: reset checks, vector table, clear-mid-frame sequence.
    initial begin
        logic [7:0] exp5 [5];
        vecs[0] = '{len: 1,   first: 8'hAB, step: 8'h00, dsel: 0, stall: 0, b2b: 0, exp_ovf: 0};
        vecs[1] = '{len: 3,   first: 8'h10, step: 8'h10, dsel: 0, stall: 1, b2b: 0, exp_ovf: 0};
        vecs[2] = '{len: 66,  first: 8'h00, step: 8'h01, dsel: 0, stall: 0, b2b: 0, exp_ovf: 1};
        vecs[3] = '{len: 5,   first: 8'h40, step: 8'h03, dsel: 0, stall: 0, b2b: 1, exp_ovf: 0};
        vecs[4] = '{len: 1,   first: 8'hC5, step: 8'h00, dsel: 0, stall: 0, b2b: 0, exp_ovf: 0};
        vecs[5] = '{len: 64,  first: 8'h80, step: 8'h01, dsel: 0, stall: 1, b2b: 0, exp_ovf: 0};
        vecs[6] = '{len: 300, first: 8'h03, step: 8'h07, dsel: 1, stall: 0, b2b: 0, exp_ovf: 0};
        vecs[7] = '{len: 2,   first: 8'hE1, step: 8'h11, dsel: 1, stall: 1, b2b: 0, exp_ovf: 0};

        repeat (3) @(negedge clk);
        clear = 1'b0;
        @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            dsel = s[0];
            #1;
            check(out_valid == 1'b0, "rst_out_valid", out_valid, 0);
            check(out_data == 8'h00, "rst_out_data", out_data, 0);
            check(out_last == 1'b0, "rst_out_last", out_last, 0);
            check(ovf == 1'b0, "rst_overflow", ovf, 0);
            check(in_ready == 1'b1, "rst_in_ready", in_ready, 1);
        end
        dsel = 1'b0;
        mon_en = 1'b1;

        for (int v = 0; v < 8; v++) begin
            dsel = vecs[v].dsel;
            stall = vecs[v].stall;
            ovf_cnt = 0;
            send_pkt(vecs[v].len, vecs[v].first, vecs[v].step, 1'b1);
            if (!vecs[v].b2b) begin
                drain();
                check(ovf_cnt == vecs[v].exp_ovf, "overflow_pulses", ovf_cnt, vecs[v].exp_ovf);
            end
        end

        // Clear in the middle of the payload of a 4-byte frame.
        dsel = 1'b0;
        stall = 1'b0;
        @(negedge clk);
        @(negedge clk);
        mon_en = 1'b0;
        exp5[0] = MAGIC; exp5[1] = 8'h04; exp5[2] = 8'h00; exp5[3] = 8'h61; exp5[4] = 8'h62;
        send_pkt(4, 8'h61, 8'h01, 1'b0);
        for (int k = 0; k < 5; k++) begin
            check(out_valid && (out_data == exp5[k]), "pre_clear_byte", out_data, exp5[k]);
            if (k < 4) @(negedge clk);
        end
        clear = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check(out_valid == 1'b0, "clear_out_valid", out_valid, 0);
        check(in_ready == 1'b1, "clear_in_ready", in_ready, 1);
        clear = 1'b0;
        pv = 1'b0; fidx = 0; cyc = 0; in_frame = 1'b0; chk_rdy = 1'b0;
        mon_en = 1'b1;
        send_pkt(1, 8'h77, 8'h00, 1'b1);
        drain();

        check(sb.size() == 0, "scoreboard_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
